// File: rtl/branch_target_buffer_pkg.sv
// ---------------------------------------------------------------------------
// brpred_pkg
// Shared definitions for the branch predictor:
//   - default geometry of the BTB
//   - 2-bit saturating counter encoding (SNT/WNT/WT/ST)
//   - ctr_next()     : saturating step toward the resolved outcome
//   - ctr_is_taken() : predict-taken decode of a counter value
// ---------------------------------------------------------------------------
package brpred_pkg;

  localparam int BTB_ADDR_W = 32;
  localparam int BTB_IDX_W  = 4;

  typedef logic [1:0] ctr_t;

  localparam ctr_t SNT = 2'b00;  // strongly not taken
  localparam ctr_t WNT = 2'b01;  // weakly not taken
  localparam ctr_t WT  = 2'b10;  // weakly taken
  localparam ctr_t ST  = 2'b11;  // strongly taken

  // Move one step toward the observed outcome, saturating at either end.
  function automatic ctr_t ctr_next(input ctr_t ctr, input logic taken);
    ctr_t nxt;
    if (taken) nxt = (ctr == ST)  ? ST  : ctr + 2'd1;
    else       nxt = (ctr == SNT) ? SNT : ctr - 2'd1;
    return nxt;
  endfunction

  // Upper half of the encoding (WT, ST) predicts taken.
  function automatic logic ctr_is_taken(input ctr_t ctr);
    return ctr[1];
  endfunction

endpackage

// File: rtl/branch_target_buffer_if.sv
// ---------------------------------------------------------------------------
// branch_target_buffer_if
// Fetch-lookup and execute-update signals of the BTB.
//   fetch_pc    : PC being fetched this cycle
//   pred_hit    : valid entry with matching tag
//   pred_taken  : hit and counter predicts taken
//   pred_target : predicted next PC (stored target or fetch_pc+4)
//   upd_en      : execute stage resolved a branch this cycle
//   upd_pc      : PC of the resolved branch
//   upd_taken   : actual outcome
//   upd_target  : actual target (meaningful when upd_taken=1)
// master = fetch/execute side, slave = the BTB.
// ---------------------------------------------------------------------------
interface branch_target_buffer_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] fetch_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [ADDR_W-1:0] pred_target;
  logic              upd_en;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;

  modport master (
    output fetch_pc, upd_en, upd_pc, upd_taken, upd_target,
    input  pred_hit, pred_taken, pred_target
  );

  modport slave (
    input  fetch_pc, upd_en, upd_pc, upd_taken, upd_target,
    output pred_hit, pred_taken, pred_target
  );
endinterface

// File: rtl/sat_counter2.sv
// ---------------------------------------------------------------------------
// sat_counter2
// Combinational 2-bit saturating counter: next state and taken decode.
//   i_ctr        : current counter value
//   i_taken      : resolved outcome to step toward
//   o_ctr_next   : saturated next value
//   o_is_taken   : current value predicts taken
// ---------------------------------------------------------------------------
module sat_counter2
  import brpred_pkg::*;
(
  input  ctr_t i_ctr,
  input  logic i_taken,
  output ctr_t o_ctr_next,
  output logic o_is_taken
);
  assign o_ctr_next = ctr_next(i_ctr, i_taken);
  assign o_is_taken = ctr_is_taken(i_ctr);
endmodule

// File: rtl/branch_target_buffer.sv
// ---------------------------------------------------------------------------
// branch_target_buffer
// Direct-mapped BTB: per entry a valid bit, tag, target and 2-bit counter.
// Lookup is combinational on fetch_pc from registered state (no bypass of a
// same-cycle update). Update is written at the clock edge.
//   clk    : rising-edge clock
//   reset  : synchronous active-high; clears valid bits and counters
//   flush  : synchronous invalidate of all entries; drops a same-cycle update
//   bus    : lookup/update signals (slave modport)
// Priority at the edge: reset > flush > update.
// ---------------------------------------------------------------------------
module branch_target_buffer
  import brpred_pkg::*;
#(
  parameter int ADDR_W = BTB_ADDR_W,
  parameter int IDX_W  = BTB_IDX_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  branch_target_buffer_if.slave  bus
);
  localparam int ENTRIES = 1 << IDX_W;
  localparam int TAG_W   = ADDR_W - IDX_W - 2;

  logic              r_valid  [ENTRIES];
  ctr_t              r_ctr    [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [ADDR_W-1:0] r_target [ENTRIES];

  // ---- lookup ------------------------------------------------------------
  logic [IDX_W-1:0] w_fetch_idx;
  logic [TAG_W-1:0] w_fetch_tag;
  logic             w_fetch_hit;
  logic             w_fetch_taken;

  assign w_fetch_idx   = bus.fetch_pc[IDX_W+1:2];
  assign w_fetch_tag   = bus.fetch_pc[ADDR_W-1:IDX_W+2];
  assign w_fetch_hit   = r_valid[w_fetch_idx] && (r_tag[w_fetch_idx] == w_fetch_tag);
  assign w_fetch_taken = w_fetch_hit && ctr_is_taken(r_ctr[w_fetch_idx]);

  assign bus.pred_hit    = w_fetch_hit;
  assign bus.pred_taken  = w_fetch_taken;
  assign bus.pred_target = w_fetch_taken ? r_target[w_fetch_idx]
                                         : bus.fetch_pc + ADDR_W'(4);

  // ---- update ------------------------------------------------------------
  logic [IDX_W-1:0] w_upd_idx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_upd_hit;
  ctr_t             w_upd_ctr_next;
  logic             w_unused_upd_is_taken;
  logic [3:0]       w_unused_pc_low;
  logic             w_upd_live;
  logic             w_ctr_we;
  logic             w_data_we;

  assign w_upd_idx = bus.upd_pc[IDX_W+1:2];
  assign w_upd_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

  sat_counter2 u_upd_ctr (
    .i_ctr      (r_ctr[w_upd_idx]),
    .i_taken    (bus.upd_taken),
    .o_ctr_next (w_upd_ctr_next),
    .o_is_taken (w_unused_upd_is_taken)
  );

  // Word-aligned PCs: the two low bits never select anything.
  assign w_unused_pc_low = {bus.fetch_pc[1:0], bus.upd_pc[1:0]};

  // An update only lands when neither reset nor flush claims the edge.
  assign w_upd_live = bus.upd_en && !reset && !flush;
  // Hits step the counter; a taken miss allocates; a not-taken miss is ignored.
  assign w_ctr_we   = w_upd_live && (w_upd_hit || bus.upd_taken);
  // Every taken resolve (hit or allocate) writes tag and target.
  assign w_data_we  = w_upd_live && bus.upd_taken;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, which is what gives lookup its no-bypass view.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= SNT;
      end
    end else if (flush) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (w_ctr_we) begin
      r_valid[w_upd_idx] <= 1'b1;
      r_ctr[w_upd_idx]   <= w_upd_hit ? w_upd_ctr_next : WT;
    end
  end

  // NOTE: tag/target storage is deliberately not reset; it is only read
  // behind a valid bit, and leaving it reset-free lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (w_data_we) begin
      r_tag[w_upd_idx]    <= w_upd_tag;
      r_target[w_upd_idx] <= bus.upd_target;
    end
  end

endmodule

// File: tb/tb_branch_target_buffer.sv
// ---------------------------------------------------------------------------
// tb_branch_target_buffer
// Self-checking bench for branch_target_buffer: directed scenarios with
// literal expectations, then randomized traffic. A behavioural model of the
// table is compared against the DUT outputs on every falling edge.
// ---------------------------------------------------------------------------
module tb_branch_target_buffer;

  logic clk = 1'b0;
  logic reset;
  logic flush;

  branch_target_buffer_if #(.ADDR_W(32)) bus ();

  branch_target_buffer #(.ADDR_W(32), .IDX_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- behavioural model: table of 16 entries keyed by (pc/4) mod 16 ----
  bit          m_init = 1'b0;
  bit          m_valid  [16];
  int unsigned m_tag    [16];
  logic [31:0] m_target [16];
  int          m_ctr    [16];

  // Inputs change 1ns after a rising edge, so at the falling edge they hold
  // the values the next rising edge will sample: check first, then advance.
  always @(negedge clk) begin
    int unsigned fi, ft, ui, ut;
    bit          e_hit, e_taken, u_hit;
    logic [31:0] e_target;
    if (m_init) begin
      fi       = (bus.fetch_pc / 4) % 16;
      ft       = bus.fetch_pc / 64;
      e_hit    = m_valid[fi] && (m_tag[fi] == ft);
      e_taken  = e_hit && (m_ctr[fi] >= 2);
      e_target = e_taken ? m_target[fi] : bus.fetch_pc + 32'd4;
      check("model_hit",    32'(bus.pred_hit),   32'(e_hit));
      check("model_taken",  32'(bus.pred_taken), 32'(e_taken));
      check("model_target", bus.pred_target,     e_target);
    end
    if (reset) begin
      m_init = 1'b1;
      for (int i = 0; i < 16; i++) begin
        m_valid[i] = 1'b0;
        m_ctr[i]   = 0;
      end
    end else if (m_init && flush) begin
      for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    end else if (m_init && bus.upd_en) begin
      ui    = (bus.upd_pc / 4) % 16;
      ut    = bus.upd_pc / 64;
      u_hit = m_valid[ui] && (m_tag[ui] == ut);
      if (u_hit) begin
        if (bus.upd_taken) begin
          m_ctr[ui]    = (m_ctr[ui] == 3) ? 3 : m_ctr[ui] + 1;
          m_target[ui] = bus.upd_target;
        end else begin
          m_ctr[ui] = (m_ctr[ui] == 0) ? 0 : m_ctr[ui] - 1;
        end
      end else if (bus.upd_taken) begin
        m_valid[ui]  = 1'b1;
        m_tag[ui]    = ut;
        m_target[ui] = bus.upd_target;
        m_ctr[ui]    = 2;
      end
    end
  end

  // ---- stimulus helpers ----
  task automatic apply(input logic rst, input logic fl, input logic [31:0] fpc,
                       input logic en, input logic [31:0] upc, input logic tk,
                       input logic [31:0] tgt);
    @(posedge clk);
    #1;
    reset          = rst;
    flush          = fl;
    bus.fetch_pc   = fpc;
    bus.upd_en     = en;
    bus.upd_pc     = upc;
    bus.upd_taken  = tk;
    bus.upd_target = tgt;
    @(negedge clk);
  endtask

  task automatic idle(input logic [31:0] fpc);
    apply(1'b0, 1'b0, fpc, 1'b0, 32'h0, 1'b0, 32'h0);
  endtask

  task automatic upd(input logic [31:0] upc, input logic tk, input logic [31:0] tgt);
    apply(1'b0, 1'b0, upc, 1'b1, upc, tk, tgt);
  endtask

  task automatic expect_pred(input string name, input logic hit, input logic tk,
                             input logic [31:0] tgt);
    check({name, "_hit"},    32'(bus.pred_hit),   32'(hit));
    check({name, "_taken"},  32'(bus.pred_taken), 32'(tk));
    check({name, "_target"}, bus.pred_target,     tgt);
  endtask

  function automatic logic [31:0] rnd_pc();
    logic [25:0] t;
    logic [3:0]  ix;
    logic [1:0]  lo;
    case ($urandom_range(0, 2))
      0:       t = 26'h0;
      1:       t = 26'h1;
      default: t = 26'h3FF_FFFF;
    endcase
    ix = 4'($urandom_range(0, 15));
    lo = 2'($urandom_range(0, 3));
    return {t, ix, lo};
  endfunction

  initial begin
    reset          = 1'b1;
    flush          = 1'b0;
    bus.fetch_pc   = 32'h100;
    bus.upd_en     = 1'b0;
    bus.upd_pc     = 32'h0;
    bus.upd_taken  = 1'b0;
    bus.upd_target = 32'h0;

    // 1: reset state
    apply(1'b1, 1'b0, 32'h100, 1'b0, 32'h0, 1'b0, 32'h0);
    idle(32'h100);
    expect_pred("reset", 1'b0, 1'b0, 32'h104);

    // 2 + 5a: allocate with same-cycle lookup (pre-update view), then hit
    upd(32'h100, 1'b1, 32'h200);
    expect_pred("same_cycle", 1'b0, 1'b0, 32'h104);
    idle(32'h100);
    expect_pred("alloc", 1'b1, 1'b1, 32'h200);

    // 3: WT -> WNT -> SNT, then saturate at SNT
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b0, 32'h0);
    idle(32'h100);
    expect_pred("snt", 1'b1, 1'b0, 32'h104);
    upd(32'h100, 1'b0, 32'h0);
    upd(32'h100, 1'b1, 32'h200);   // SNT stays SNT, so this lands on WNT
    idle(32'h100);
    expect_pred("sat_low", 1'b1, 1'b0, 32'h104);

    // 4: alias on index 0 replaces the entry
    upd(32'h140, 1'b1, 32'h300);
    idle(32'h100);
    expect_pred("alias_old", 1'b0, 1'b0, 32'h104);
    idle(32'h140);
    expect_pred("alias_new", 1'b1, 1'b1, 32'h300);
    idle(32'h143);
    expect_pred("low_bits", 1'b1, 1'b1, 32'h300);

    // 5: flush, and flush dropping a same-cycle update
    upd(32'h248, 1'b1, 32'h500);
    idle(32'h248);
    expect_pred("pre_flush", 1'b1, 1'b1, 32'h500);
    apply(1'b0, 1'b1, 32'h248, 1'b0, 32'h0, 1'b0, 32'h0);
    expect_pred("flush_cycle", 1'b1, 1'b1, 32'h500);
    idle(32'h248);
    expect_pred("post_flush", 1'b0, 1'b0, 32'h24C);
    apply(1'b0, 1'b1, 32'h248, 1'b1, 32'h248, 1'b1, 32'h600);
    idle(32'h248);
    expect_pred("flush_drop", 1'b0, 1'b0, 32'h24C);

    // reset mid-operation discards the update of that cycle
    upd(32'h180, 1'b1, 32'h600);
    idle(32'h180);
    expect_pred("pre_reset", 1'b1, 1'b1, 32'h600);
    apply(1'b1, 1'b0, 32'h180, 1'b1, 32'h1C0, 1'b1, 32'h700);
    idle(32'h1C0);
    expect_pred("reset_drop", 1'b0, 1'b0, 32'h1C4);
    idle(32'h180);
    expect_pred("reset_clear", 1'b0, 1'b0, 32'h184);

    // 6: fall-through wraps
    idle(32'hFFFF_FFFC);
    expect_pred("wrap", 1'b0, 1'b0, 32'h0000_0000);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] upc;
      upc = rnd_pc();
      apply(($urandom_range(0, 199) == 0),
            ($urandom_range(0, 49) == 0),
            ($urandom_range(0, 3) == 0) ? upc : rnd_pc(),
            ($urandom_range(0, 9) < 6),
            upc,
            ($urandom_range(0, 9) < 6),
            $urandom());
    end

    idle(32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
